// File: rtl/stq_mempipe_ctl_if.sv
// Shared store-pipe types and the request/grant/mm5 bundle between the store queue
// entries (master) and stq_mempipe_ctl (slave).
package stq_mempipe_pkg;
  localparam int STQ_NUM_ENTRIES = 4;
  localparam int STQ_ID_W = $clog2(STQ_NUM_ENTRIES);

  typedef enum logic {
    MEM_ST_INITIAL = 1'b0,
    MEM_ST_FINAL   = 1'b1
  } t_mem_st;

  typedef struct packed {
    t_mem_st st;
  } t_mempipe_phase;

  typedef struct packed {
    t_mempipe_phase        phase;
    logic [STQ_ID_W-1:0]   stq_id;
    logic [31:0]           addr;
    logic [63:0]           arb_data;
    logic [7:0]            byte_en;
  } t_mempipe_arb;

  typedef struct packed {
    logic complete;
    logic recycle;
  } t_mempipe_action;
endpackage

// Handshake: an entry holds req_mm0[i] with a stable req_pkt_mm0[i]; gnt_mm0[i] in the
// same cycle consumes the request (valid & grant == transfer). After mm0 there is no
// backpressure: the mm5 valid/action and the dcache write strobe are single-cycle pulses.
interface stq_mempipe_ctl_if
  import stq_mempipe_pkg::*;
#(
  parameter int NUM_REQ = STQ_NUM_ENTRIES
) ();
  logic [NUM_REQ-1:0] req_mm0;
  t_mempipe_arb       req_pkt_mm0 [NUM_REQ];
  logic               arb_block_mm0;
  logic [NUM_REQ-1:0] gnt_mm0;
  logic               flush;
  logic               pipe_valid_mm5;
  t_mempipe_arb       pipe_req_pkt_mm5;
  t_mempipe_action    pipe_action_mm5;
  logic               dc_wr_valid_mm5;
  t_mempipe_arb       dc_wr_pkt_mm5;
  logic               dc_wr_credit_rtn;

  modport master (
    output req_mm0, req_pkt_mm0, arb_block_mm0, flush, dc_wr_credit_rtn,
    input  gnt_mm0, pipe_valid_mm5, pipe_req_pkt_mm5, pipe_action_mm5,
           dc_wr_valid_mm5, dc_wr_pkt_mm5
  );

  modport slave (
    input  req_mm0, req_pkt_mm0, arb_block_mm0, flush, dc_wr_credit_rtn,
    output gnt_mm0, pipe_valid_mm5, pipe_req_pkt_mm5, pipe_action_mm5,
           dc_wr_valid_mm5, dc_wr_pkt_mm5
  );
endinterface

// File: rtl/stq_mempipe_ctl.sv
// Store-side memory-pipe controller: round-robin mm0 arbitration, mm1-mm5 carry pipe,
// mm5 complete/recycle with credit-gated dcache write. STQ_MEMPIPE_PERF_EN adds perf counters.
module stq_mempipe_ctl
  import stq_mempipe_pkg::*;
#(
  parameter int NUM_REQ    = STQ_NUM_ENTRIES,
  parameter int WR_CREDITS = 4,
  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CRED_W    = $clog2(WR_CREDITS + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  stq_mempipe_ctl_if.slave    mp,
  output logic [PTR_W-1:0]    dbg_rr_ptr,
  output logic [CRED_W-1:0]   dbg_credits
`ifdef STQ_MEMPIPE_PERF_EN
  ,
  output logic [31:0]         perf_grants,
  output logic [31:0]         perf_recycles,
  output logic [31:0]         perf_credit_stalls
`endif
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(WR_CREDITS);

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               found;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   rr_ptr;

  logic [5:1]         stg_v;
  logic [5:1]         stg_k;
  t_mempipe_arb       stg_pkt [1:5];

  logic [CRED_W-1:0]  credits;
  logic [CRED_W-1:0]  credits_nxt;
  t_mempipe_action    act;
  logic               wr_fire;
  logic               credit_stall;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A load pipe owning mm0 suppresses every store request for this cycle.
  assign elig = mp.req_mm0 & {NUM_REQ{~mp.arb_block_mm0}};

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    win   = '0;
    cand  = rr_ptr;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = wrap_inc(cand);
    end
    if (found) gnt[win] = 1'b1;
  end

  assign mp.gnt_mm0 = gnt;

  // Valid/killed bits are the only pipe state that needs a reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_v  <= '0;
      stg_k  <= '0;
      rr_ptr <= '0;
    end else begin
      stg_v[1] <= found;
      stg_k[1] <= mp.flush;
      for (int s = 2; s <= 5; s++) begin
        stg_v[s] <= stg_v[s-1];
        stg_k[s] <= stg_k[s-1] | mp.flush;
      end
      if (found) rr_ptr <= wrap_inc(win);
    end
  end

  always_ff @(posedge clk) begin
    stg_pkt[1] <= mp.req_pkt_mm0[win];
    for (int s = 2; s <= 5; s++) begin
      stg_pkt[s] <= stg_pkt[s-1];
    end
  end

  // A flush seen while the packet sits in mm5 kills it in that same cycle.
  always_comb begin
    act          = '0;
    wr_fire      = 1'b0;
    credit_stall = 1'b0;
    if (stg_v[5]) begin
      if (stg_k[5] || mp.flush) begin
        act.recycle = 1'b1;
      end else if (stg_pkt[5].phase.st == MEM_ST_FINAL) begin
        if (credits != '0) begin
          act.complete = 1'b1;
          wr_fire      = 1'b1;
        end else begin
          act.recycle  = 1'b1;
          credit_stall = 1'b1;
        end
      end else begin
        act.complete = 1'b1;
      end
    end
  end

  assign mp.pipe_valid_mm5   = stg_v[5];
  assign mp.pipe_req_pkt_mm5 = stg_pkt[5];
  assign mp.pipe_action_mm5  = act;
  assign mp.dc_wr_valid_mm5  = wr_fire;
  assign mp.dc_wr_pkt_mm5    = stg_pkt[5];

  always_comb begin
    credits_nxt = credits;
    case ({wr_fire, mp.dc_wr_credit_rtn})
      2'b10:   credits_nxt = credits - CRED_W'(1);
      2'b01:   if (credits != CRED_MAX) credits_nxt = credits + CRED_W'(1);
      default: credits_nxt = credits;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      credits <= CRED_MAX;
    end else begin
      credits <= credits_nxt;
    end
  end

  assign dbg_rr_ptr  = rr_ptr;
  assign dbg_credits = credits;

`ifdef STQ_MEMPIPE_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_grants        <= '0;
      perf_recycles      <= '0;
      perf_credit_stalls <= '0;
    end else begin
      if (found)        perf_grants        <= perf_grants + 32'd1;
      if (act.recycle)  perf_recycles      <= perf_recycles + 32'd1;
      if (credit_stall) perf_credit_stalls <= perf_credit_stalls + 32'd1;
    end
  end
`endif

`ifdef ASSERT
  `ifndef VASSERT
    `define VASSERT(cond, msg) assert (cond) else $error(msg)
  `endif
  // A return at full credits means the dcache handed back more than it was given.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      `VASSERT(!(mp.dc_wr_credit_rtn && !wr_fire && credits == CRED_MAX), "stq_mempipe_ctl: credit return overflow");
    end
  end
`endif

endmodule

// File: tb/tb_stq_mempipe_ctl.sv
// Directed bench for stq_mempipe_ctl: drivers push expected mm5 results into a queue,
// an independent negedge monitor pops and compares them.
module tb_stq_mempipe_ctl;
  import stq_mempipe_pkg::*;

  localparam int NUM_REQ    = 4;
  localparam int WR_CREDITS = 2;
  localparam int PTR_W      = 2;
  localparam int CRED_W     = $clog2(WR_CREDITS + 1);
  localparam int PKT_W      = $bits(t_mempipe_arb);
  localparam int EXP_W      = PKT_W + 3;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [EXP_W-1:0] mon_e;
  int               mon_c;

  stq_mempipe_ctl_if #(.NUM_REQ(NUM_REQ)) mp_if ();
  logic [PTR_W-1:0]  dbg_rr_ptr;
  logic [CRED_W-1:0] dbg_credits;
`ifdef STQ_MEMPIPE_PERF_EN
  logic [31:0] perf_grants, perf_recycles, perf_credit_stalls;
`endif

  stq_mempipe_ctl #(
    .NUM_REQ    (NUM_REQ),
    .WR_CREDITS (WR_CREDITS)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mp          (mp_if),
    .dbg_rr_ptr  (dbg_rr_ptr),
    .dbg_credits (dbg_credits)
`ifdef STQ_MEMPIPE_PERF_EN
    ,
    .perf_grants        (perf_grants),
    .perf_recycles      (perf_recycles),
    .perf_credit_stalls (perf_credit_stalls)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (mp_if.pipe_valid_mm5 === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mm5_unexpected: got valid packet, expected none (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          chk("mm5_cycle", cyc, mon_c);
          chk("mm5_pkt", mp_if.pipe_req_pkt_mm5, mon_e[EXP_W-1:3]);
          chk("mm5_complete", mp_if.pipe_action_mm5.complete, mon_e[2]);
          chk("mm5_recycle", mp_if.pipe_action_mm5.recycle, mon_e[1]);
          chk("dc_wr_valid", mp_if.dc_wr_valid_mm5, mon_e[0]);
          if (mon_e[0]) chk("dc_wr_pkt", mp_if.dc_wr_pkt_mm5, mon_e[EXP_W-1:3]);
        end
      end else begin
        chk("idle_action", {mp_if.pipe_action_mm5, mp_if.dc_wr_valid_mm5}, 3'b000);
      end
    end
  end

  // driver tasks
  task automatic set_pkt(input int i, input t_mem_st st, input logic [31:0] addr);
    t_mempipe_arb p;
    p.phase.st = st;
    p.stq_id   = 2'(i);
    p.addr     = addr;
    p.arb_data = {addr, ~addr};
    p.byte_en  = addr[7:0] | 8'h01;
    mp_if.req_pkt_mm0[i] = p;
  endtask

  // One cycle of stimulus; a grant with an expected action (complete or recycle) is
  // scheduled to show up at mm5 five cycles later.
  task automatic drive(input logic [3:0] req, input logic blk, input logic fl, input logic rtn,
                       input logic [3:0] exp_gnt, input logic e_cmp, input logic e_rcy,
                       input logic e_wr);
    mp_if.req_mm0          = req;
    mp_if.arb_block_mm0    = blk;
    mp_if.flush            = fl;
    mp_if.dc_wr_credit_rtn = rtn;
    @(negedge clk);
    chk("gnt_mm0", mp_if.gnt_mm0, exp_gnt);
    if (e_cmp || e_rcy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_gnt[i]) begin
          exp_q.push_back({mp_if.req_pkt_mm0[i], e_cmp, e_rcy, e_wr});
          exp_cyc_q.push_back(cyc + 5);
        end
      end
    end
    @(posedge clk);
    #1;
    mp_if.req_mm0          = '0;
    mp_if.arb_block_mm0    = 1'b0;
    mp_if.flush            = 1'b0;
    mp_if.dc_wr_credit_rtn = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n                = 1'b0;
    mp_if.req_mm0          = '0;
    mp_if.arb_block_mm0    = 1'b0;
    mp_if.flush            = 1'b0;
    mp_if.dc_wr_credit_rtn = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_pkt(i, MEM_ST_INITIAL, 32'h1000_0000 + 32'(i * 16));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", mp_if.gnt_mm0, 4'b0000);
    chk("rst_valid_mm5", mp_if.pipe_valid_mm5, 1'b0);
    chk("rst_action", mp_if.pipe_action_mm5, 2'b00);
    chk("rst_dc_wr", mp_if.dc_wr_valid_mm5, 1'b0);
    chk("rst_rr_ptr", dbg_rr_ptr, 2'd0);
    chk("rst_credits", dbg_credits, 2'd2);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // entries 1 and 3 together from rr_ptr 0: grant 1, then 3
    drive(4'b1010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("rr_after_pair", dbg_rr_ptr, 2'd0);

    // single INITIAL passes through unchanged
    set_pkt(2, MEM_ST_INITIAL, 32'hCAFE_0040);
    drive(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    idle(5);

    // FINAL complete coincides with a credit return: credits stays at 2
    set_pkt(0, MEM_ST_FINAL, 32'hBEEF_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    idle(4);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("credits_wr_and_rtn", dbg_credits, 2'd2);

    // drain to one credit, then two FINALs back to back: first writes, second recycles
    set_pkt(1, MEM_ST_FINAL, 32'h0000_1110);
    drive(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b1);
    idle(5);
    chk("credits_one_left", dbg_credits, 2'd1);
    set_pkt(2, MEM_ST_FINAL, 32'h0000_2220);
    set_pkt(3, MEM_ST_FINAL, 32'h0000_3330);
    drive(4'b1100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("credits_empty", dbg_credits, 2'd0);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("credits_returned", dbg_credits, 2'd1);
    drive(4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b1);
    idle(5);
    chk("credits_after_retry", dbg_credits, 2'd0);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("credits_saturate", dbg_credits, 2'd2);

    // flush two cycles after a FINAL grant, plus a grant in the flush cycle
    set_pkt(0, MEM_ST_FINAL, 32'h0F0F_0000);
    set_pkt(1, MEM_ST_INITIAL, 32'h0F0F_0010);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0);
    idle(1);
    drive(4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b1, 1'b0);
    idle(6);
    chk("credits_after_flush", dbg_credits, 2'd2);

    // flush landing while the packet is in mm5
    set_pkt(2, MEM_ST_INITIAL, 32'h5A5A_0020);
    drive(4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0);
    idle(4);
    drive(4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rr_before_block", dbg_rr_ptr, 2'd3);

    // arb_block masks everything and freezes rr_ptr
    set_pkt(3, MEM_ST_INITIAL, 32'h7777_0030);
    drive(4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("rr_blocked", dbg_rr_ptr, 2'd3);
    drive(4'b1111, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
    idle(5);
    chk("rr_after_unblock", dbg_rr_ptr, 2'd0);

    // reset pulse mid-flight drops the in-flight packet and restores credits
    set_pkt(0, MEM_ST_FINAL, 32'h9999_0000);
    drive(4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    idle(5);
    chk("credits_pre_reset", dbg_credits, 2'd1);
    drive(4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    idle(3);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid_mm5", mp_if.pipe_valid_mm5, 1'b0);
    chk("midrst_action", mp_if.pipe_action_mm5, 2'b00);
    chk("midrst_dc_wr", mp_if.dc_wr_valid_mm5, 1'b0);
    chk("midrst_gnt", mp_if.gnt_mm0, 4'b0000);
    chk("midrst_credits", dbg_credits, 2'd2);
    chk("midrst_rr_ptr", dbg_rr_ptr, 2'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(7);

    chk("exp_q_drained", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
